// File: rtl/boot_loader_ctrl.sv
// Boot loader: receives an image over UART, writes it to RAM,
// acknowledges, then releases the core from reset.
module boot_loader_ctrl #(
  parameter int         MEM     = 10,
  parameter int         BASE    = 32,
  parameter logic [7:0] ACK_OK  = 8'hAA,
  parameter logic [7:0] ACK_ERR = 8'hEE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rdata,
  input  logic           rx_ready,
  output logic           next,
  input  logic           tx_busy,
  output logic [7:0]     sdata,
  output logic           tx_ready,
  output logic           memwe,
  output logic [MEM-1:0] memaddr,
  output logic [31:0]    memdin,
  output logic           loading,
  output logic           core_rstn,
  output logic           err
);

  typedef enum logic [2:0] {
    S_HDR, S_DATA, S_WRITE, S_ACK, S_RUN, S_ERR, S_HALT
  } state_t;

  localparam logic [32:0] LIM = (33'd1 << MEM) - 33'(BASE);

  state_t      state, state_n;
  logic [23:0] sh;
  logic [1:0]  bcnt;
  logic [31:0] cnt;
  logic [31:0] widx;
  logic [31:0] word;
  logic        accept;
  logic        last;

  assign accept = next & rx_ready &
                  ((state == S_HDR) | (state == S_DATA));
  assign last   = accept & (bcnt == 2'd3);
  assign word   = {rdata, sh};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_HDR: begin
        if (last) begin
          if (word == 32'd0)          state_n = S_ACK;
          else if ({1'b0, word} > LIM) state_n = S_ERR;
          else                        state_n = S_DATA;
        end
      end
      S_DATA:  if (last) state_n = S_WRITE;
      S_WRITE: begin
        if (widx + 32'd1 == cnt) state_n = S_ACK;
        else                     state_n = S_DATA;
      end
      S_ACK:   if (!tx_busy) state_n = S_RUN;
      S_ERR:   if (!tx_busy) state_n = S_HALT;
      S_RUN:   state_n = S_RUN;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_HDR;
    endcase
  end

  // Decoded outputs
  always_comb begin
    memwe     = (state == S_WRITE);
    loading   = (state != S_RUN);
    core_rstn = (state == S_RUN);
    err       = (state == S_ERR) | (state == S_HALT);
    tx_ready  = ((state == S_ACK) | (state == S_ERR)) & ~tx_busy;
  end

  // Byte packing, counters and held RAM/UART outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      bcnt    <= '0;
      cnt     <= '0;
      widx    <= '0;
      memaddr <= '0;
      memdin  <= '0;
      sdata   <= '0;
      next    <= 1'b0;
    end else begin
      next <= (state_n == S_HDR) | (state_n == S_DATA);
      if (accept) begin
        sh   <= word[31:8];
        bcnt <= bcnt + 2'd1;
      end
      if (last && state == S_HDR) begin
        cnt  <= word;
        widx <= '0;
      end
      if (last && state == S_DATA) begin
        memdin  <= word;
        memaddr <= MEM'(BASE) + widx[MEM-1:0];
      end
      if (state == S_WRITE)
        widx <= widx + 32'd1;
      if (state != S_ACK && state_n == S_ACK)
        sdata <= ACK_OK;
      if (state != S_ERR && state_n == S_ERR)
        sdata <= ACK_ERR;
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: directed images, scoreboard
// queues for RAM writes and UART acknowledges.
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rdata = '0;
  logic        rx_ready = 1'b0;
  logic        tx_busy = 1'b0;
  logic        next;
  logic [7:0]  sdata;
  logic        tx_ready;
  logic        memwe;
  logic [9:0]  memaddr;
  logic [31:0] memdin;
  logic        loading;
  logic        core_rstn;
  logic        err;

  boot_loader_ctrl dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready),
    .next(next), .tx_busy(tx_busy), .sdata(sdata),
    .tx_ready(tx_ready), .memwe(memwe), .memaddr(memaddr),
    .memdin(memdin), .loading(loading), .core_rstn(core_rstn),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] txq[$];
  int         errs = 0;
  int         checks = 0;
  int         nwr = 0;
  logic [9:0] last_addr = '0;
  logic       prev_tx = 1'b0;
  logic [7:0] last_ack = '0;
  wr_t        e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [31:0] act);
    checks++;
    errs++;
    $display("FAIL %s: got %h want no event", nm, act);
  endtask

  // Monitor: compare every write and every strobe against queues
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_tx)
        chk("post_strobe_rstn", core_rstn, last_ack == 8'hAA);
      if (memwe) begin
        chk("wr_next_low", next, 0);
        if (wq.size() == 0) unexp("wr_unexpected", memaddr);
        else begin
          e = wq.pop_front();
          chk("wr_addr", memaddr, e.a);
          chk("wr_data", memdin, e.d);
        end
        last_addr = memaddr;
        nwr++;
      end
      if (tx_ready) begin
        chk("tx_consec", prev_tx, 0);
        chk("tx_core_held", core_rstn, 0);
        if (txq.size() == 0) unexp("tx_unexpected", sdata);
        else begin
          last_ack = txq.pop_front();
          chk("tx_sdata", sdata, last_ack);
        end
      end
      prev_tx = tx_ready;
    end else begin
      prev_tx = 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!next && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!next) unexp("send_timeout", b);
    rdata = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  task automatic wait_run(input string nm);
    int n = 0;
    while (!core_rstn && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, core_rstn, 1);
    @(negedge clk);
    chk({nm, "_loading"}, loading, 0);
  endtask

  task automatic drain(input string nm);
    chk({nm, "_wq"}, wq.size(), 0);
    chk({nm, "_txq"}, txq.size(), 0);
  endtask

  logic [7:0] strm [13];
  int         w0;

  initial begin
    // reset values while rst is held
    repeat (2) @(negedge clk);
    chk("rst_next", next, 0);
    chk("rst_memwe", memwe, 0);
    chk("rst_loading", loading, 1);
    chk("rst_core_rstn", core_rstn, 0);
    chk("rst_err", err, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_memdin", memdin, 0);
    rst = 1'b0;

    // two-word image
    wq.push_back('{10'd32, 32'h0010_0513});
    wq.push_back('{10'd33, 32'h0020_0593});
    txq.push_back(8'hAA);
    send_word(32'd2);
    send_word(32'h0010_0513);
    send_word(32'h0020_0593);
    wait_run("t1_run");
    chk("t1_sdata_hold", sdata, 8'hAA);
    chk("t1_next", next, 0);
    chk("t1_err", err, 0);
    drain("t1");

    // zero-length image
    do_reset();
    w0 = nwr;
    txq.push_back(8'hAA);
    send_word(32'd0);
    wait_run("t2_run");
    chk("t2_no_write", nwr - w0, 0);
    drain("t2");

    // oversize header rejected
    do_reset();
    w0 = nwr;
    txq.push_back(8'hEE);
    send_word(32'd993);
    repeat (30) @(negedge clk);
    chk("t3_err", err, 1);
    chk("t3_core_rstn", core_rstn, 0);
    chk("t3_loading", loading, 1);
    chk("t3_next", next, 0);
    chk("t3_sdata", sdata, 8'hEE);
    chk("t3_no_write", nwr - w0, 0);
    drain("t3");

    // largest image fills up to the last word
    do_reset();
    w0 = nwr;
    for (int k = 0; k < 992; k++)
      wq.push_back('{10'(32 + k), 32'hA500_0000 | k});
    txq.push_back(8'hAA);
    send_word(32'd992);
    for (int k = 0; k < 992; k++)
      send_word(32'hA500_0000 | k);
    wait_run("t3b_run");
    chk("t3b_last_addr", last_addr, 10'd1023);
    chk("t3b_count", nwr - w0, 992);
    drain("t3b");

    // continuous rx_ready: byte during WRITE is not taken
    do_reset();
    strm = '{8'h02, 8'h00, 8'h00, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44,
             8'hFF, 8'h55, 8'h66, 8'h77, 8'h88};
    wq.push_back('{10'd32, 32'h4433_2211});
    wq.push_back('{10'd33, 32'h8877_6655});
    txq.push_back(8'hAA);
    @(negedge clk);
    while (!next) @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rdata = strm[i];
      rx_ready = 1'b1;
      @(negedge clk);
    end
    rx_ready = 1'b0;
    wait_run("t4_run");
    drain("t4");

    // transmitter busy delays the acknowledge
    do_reset();
    tx_busy = 1'b1;
    wq.push_back('{10'd32, 32'hDEAD_BEEF});
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    repeat (20) @(negedge clk);
    chk("t5_busy_rstn", core_rstn, 0);
    chk("t5_busy_loading", loading, 1);
    txq.push_back(8'hAA);
    tx_busy = 1'b0;
    wait_run("t5_run");
    drain("t5");

    // reset between bytes 2 and 3 of the first word
    do_reset();
    w0 = nwr;
    send_word(32'd1);
    send(8'h11);
    send(8'h22);
    rst = 1'b1;
    #1;
    chk("t6_async_next", next, 0);
    chk("t6_async_memwe", memwe, 0);
    chk("t6_async_loading", loading, 1);
    chk("t6_async_rstn", core_rstn, 0);
    @(negedge clk);
    rst = 1'b0;
    wq.push_back('{10'd32, 32'h0BAD_F00D});
    txq.push_back(8'hAA);
    send_word(32'd1);
    send_word(32'h0BAD_F00D);
    wait_run("t6_run");
    chk("t6_one_write", nwr - w0, 1);
    drain("t6");

    // reset during the WRITE cycle drops memwe at once
    do_reset();
    send_word(32'd1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    @(negedge clk);
    while (!next) @(negedge clk);
    rdata = 8'h04;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t7_write_hi", memwe, 1);
    chk("t7_write_addr", memaddr, 10'd32);
    rx_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t7_async_memwe", memwe, 0);
    chk("t7_async_memaddr", memaddr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_back_hdr", next, 1);
    drain("t7");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
